// File: rtl/lv_spi_master_if.sv
// Request/response and SPI pin bundle for lv_spi_master.
// The master modport is the initiator's view; slave is the harness/bridge view.
interface lv_spi_master_if #(
  parameter int FRAME_W = 16
);
  logic               i_start;
  logic [FRAME_W-1:0] i_tx_data;
  logic               i_abort;
  logic               o_ready;
  logic [FRAME_W-1:0] o_rx_data;
  logic               o_rx_vld;
  logic               o_spi_sclk;
  logic               o_spi_csb;
  logic               o_spi_mosi;
  logic               i_spi_miso;

  modport master (
    input  i_start, i_tx_data, i_abort, i_spi_miso,
    output o_ready, o_rx_data, o_rx_vld, o_spi_sclk, o_spi_csb, o_spi_mosi
  );

  modport slave (
    output i_start, i_tx_data, i_abort, i_spi_miso,
    input  o_ready, o_rx_data, o_rx_vld, o_spi_sclk, o_spi_csb, o_spi_mosi
  );
endinterface

// File: rtl/lv_spi_master.sv
// Mode-0 SPI initiator for the LV die core: one full-duplex MSB-first frame per request.
// All pin outputs are registered; SCLK only toggles on half-period terminal count.
module lv_spi_master #(
  parameter int FRAME_W = 16,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  lv_spi_master_if.master bus
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(FRAME_W + 1);
  localparam int GW = $clog2(CS_GAP + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);
  // GAP ends one cycle early so the next request is sampled exactly CS_GAP edges after CSB rises.
  localparam logic [GW-1:0] GAP_LAST = GW'((CS_GAP > 1) ? CS_GAP - 2 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam state_t GAP_ENTRY = (CS_GAP > 1) ? ST_GAP : ST_IDLE;

  state_t             state_q, state_d;
  logic [DW-1:0]      div_q, div_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [FRAME_W-1:0] tx_sr_q, tx_sr_d;
  logic [FRAME_W-1:0] rx_sr_q, rx_sr_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_vld_q, rx_vld_d;
  logic               sclk_q, sclk_d;
  logic               csb_q, csb_d;
  logic               mosi_q, mosi_d;
  logic               div_term;

  assign div_term = (div_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    rx_vld_d  = 1'b0;
    sclk_d    = sclk_q;
    csb_d     = csb_q;
    mosi_d    = mosi_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          tx_sr_d = bus.i_tx_data;
          rx_sr_d = '0;
          csb_d   = 1'b0;
          mosi_d  = bus.i_tx_data[FRAME_W-1];
          div_d   = '0;
          bit_d   = '0;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP, ST_SHIFT, ST_HOLD: begin
        if (bus.i_abort) begin
          // Abort beats any edge due this cycle, including a sampling rise.
          sclk_d  = 1'b0;
          csb_d   = 1'b1;
          mosi_d  = 1'b0;
          gap_d   = '0;
          state_d = GAP_ENTRY;
        end else if (!div_term) begin
          div_d = div_q + DW'(1);
        end else begin
          div_d = '0;
          case (state_q)
            ST_SETUP: begin
              sclk_d  = 1'b1;
              rx_sr_d = {rx_sr_q[FRAME_W-2:0], bus.i_spi_miso};
              state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
              if (sclk_q) begin
                sclk_d  = 1'b0;
                tx_sr_d = tx_sr_q << 1;
                mosi_d  = tx_sr_q[FRAME_W-2];
                bit_d   = bit_q + BW'(1);
                if (bit_q == BIT_LAST) begin
                  mosi_d  = 1'b0;
                  state_d = ST_HOLD;
                end
              end else begin
                sclk_d  = 1'b1;
                rx_sr_d = {rx_sr_q[FRAME_W-2:0], bus.i_spi_miso};
              end
            end
            default: begin
              csb_d     = 1'b1;
              rx_data_d = rx_sr_q;
              rx_vld_d  = 1'b1;
              gap_d     = '0;
              state_d   = GAP_ENTRY;
            end
          endcase
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      gap_q     <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      rx_vld_q  <= 1'b0;
      sclk_q    <= 1'b0;
      csb_q     <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      gap_q     <= gap_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      rx_vld_q  <= rx_vld_d;
      sclk_q    <= sclk_d;
      csb_q     <= csb_d;
      mosi_q    <= mosi_d;
    end
  end

  assign bus.o_ready    = (state_q == ST_IDLE);
  assign bus.o_rx_data  = rx_data_q;
  assign bus.o_rx_vld   = rx_vld_q;
  assign bus.o_spi_sclk = sclk_q;
  assign bus.o_spi_csb  = csb_q;
  assign bus.o_spi_mosi = mosi_q;
endmodule

// File: tb/tb_lv_spi_master.sv
// Bench for lv_spi_master: default 16-bit/div-4 instance with loopback or slave model,
// plus an 8-bit/div-1 instance in loopback.
module tb_lv_spi_master;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lv_spi_master_if #(.FRAME_W(16)) bus_a ();
  lv_spi_master_if #(.FRAME_W(8))  bus_b ();

  lv_spi_master #(.FRAME_W(16), .CLK_DIV(4), .CS_GAP(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(bus_a)
  );
  lv_spi_master #(.FRAME_W(8), .CLK_DIV(1), .CS_GAP(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(bus_b)
  );

  // Slave model: receives on SCLK rise, shifts its reply out on SCLK fall.
  logic        loop_a;
  logic        slave_miso;
  logic [15:0] slave_tx, slave_sh, slave_rx;

  assign bus_a.i_spi_miso = loop_a ? bus_a.o_spi_mosi : slave_miso;
  assign bus_b.i_spi_miso = bus_b.o_spi_mosi;

  initial begin slave_miso = 1'b0; slave_tx = '0; slave_sh = '0; slave_rx = '0; end
  always @(negedge bus_a.o_spi_csb) begin
    slave_sh   = slave_tx;
    slave_miso = slave_tx[15];
    slave_rx   = '0;
  end
  always @(posedge bus_a.o_spi_sclk) slave_rx = {slave_rx[14:0], bus_a.o_spi_mosi};
  always @(negedge bus_a.o_spi_sclk) begin
    if (bus_a.o_spi_csb === 1'b0) begin
      slave_sh   = slave_sh << 1;
      slave_miso = slave_sh[15];
    end
  end

  // Per-cycle capture; index j = outputs seen after edge E0+j.
  logic        c_sclk[256], c_csb[256], c_mosi[256], c_vld[256], c_rdy[256];
  logic [15:0] c_rxd[256];
  int n_rise, j_vld, n_vld, n_csblow, j_rdy, sclk_err, mosi_err;
  logic [15:0] rx_last;

  task automatic launch(input bit sel_b, input logic [15:0] tx, input bit with_abort);
    int w;
    w = 0;
    @(negedge clk);
    while (((sel_b ? bus_b.o_ready : bus_a.o_ready) !== 1'b1) && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (w >= 400) begin
      n_cmp++; n_bad++;
      $display("FAIL launch_ready_timeout: ready never rose within %0d cycles", w);
    end
    if (sel_b) begin
      bus_b.i_tx_data = tx[7:0];
      bus_b.i_start   = 1'b1;
    end else begin
      bus_a.i_tx_data = tx;
      bus_a.i_start   = 1'b1;
      bus_a.i_abort   = with_abort;
    end
    @(posedge clk);
    #1;
    bus_a.i_start   = 1'b0;
    bus_b.i_start   = 1'b0;
    bus_a.i_abort   = 1'b0;
    bus_a.i_tx_data = 16'($urandom);
    bus_b.i_tx_data = 8'($urandom);
  endtask

  task automatic capture(input bit sel_b, input int n, input int abort_j);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (sel_b) begin
        c_sclk[j] = bus_b.o_spi_sclk; c_csb[j] = bus_b.o_spi_csb; c_mosi[j] = bus_b.o_spi_mosi;
        c_vld[j]  = bus_b.o_rx_vld;   c_rdy[j] = bus_b.o_ready;   c_rxd[j]  = {8'h00, bus_b.o_rx_data};
      end else begin
        c_sclk[j] = bus_a.o_spi_sclk; c_csb[j] = bus_a.o_spi_csb; c_mosi[j] = bus_a.o_spi_mosi;
        c_vld[j]  = bus_a.o_rx_vld;   c_rdy[j] = bus_a.o_ready;   c_rxd[j]  = bus_a.o_rx_data;
      end
      bus_a.i_abort = (j == abort_j - 1);
    end
  endtask

  // Summarise a capture and compare waveforms against the ideal mode-0 timing for (F, D).
  task automatic analyze(input int n, input int F, input int D, input logic [15:0] tx);
    logic exp_sclk, exp_mosi;
    n_rise = 0; j_vld = -1; n_vld = 0; n_csblow = 0; j_rdy = -1; sclk_err = 0; mosi_err = 0;
    for (int j = 0; j < n; j++) begin
      if (j > 0 && c_sclk[j] === 1'b1 && c_sclk[j-1] === 1'b0) n_rise++;
      if (c_vld[j] === 1'b1) begin n_vld++; if (j_vld < 0) j_vld = j; end
      if (c_csb[j] === 1'b0) n_csblow++;
      if (c_rdy[j] === 1'b1 && j_rdy < 0) j_rdy = j;
      exp_sclk = (j >= D && j < (2*F+1)*D) ? (((j / D) % 2) == 1) : 1'b0;
      exp_mosi = (j < 2*F*D) ? tx[F-1 - j/(2*D)] : 1'b0;
      if (c_sclk[j] !== exp_sclk) sclk_err++;
      if (c_mosi[j] !== exp_mosi) mosi_err++;
    end
    rx_last = c_rxd[n-1];
  endtask

  task automatic test_reset;
    n_cmp++; if (bus_a.o_spi_csb !== 1'b1) begin n_bad++; $display("FAIL rst_csb: got %b want 1", bus_a.o_spi_csb); end
    n_cmp++; if (bus_a.o_spi_sclk !== 1'b0) begin n_bad++; $display("FAIL rst_sclk: got %b want 0", bus_a.o_spi_sclk); end
    n_cmp++; if (bus_a.o_spi_mosi !== 1'b0) begin n_bad++; $display("FAIL rst_mosi: got %b want 0", bus_a.o_spi_mosi); end
    n_cmp++; if (bus_a.o_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", bus_a.o_ready); end
    n_cmp++; if (bus_a.o_rx_vld !== 1'b0) begin n_bad++; $display("FAIL rst_vld: got %b want 0", bus_a.o_rx_vld); end
    n_cmp++; if (bus_a.o_rx_data !== 16'h0) begin n_bad++; $display("FAIL rst_rxdata: got %h want 0000", bus_a.o_rx_data); end
    n_cmp++; if (bus_b.o_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_b: got %b want 1", bus_b.o_ready); end
    @(negedge clk);
    rst = 1'b0;
    // Reset in the middle of a frame.
    loop_a = 1'b1;
    launch(1'b0, 16'hFFFF, 1'b0);
    repeat (40) @(negedge clk);
    n_cmp++; if (bus_a.o_spi_csb !== 1'b0) begin n_bad++; $display("FAIL midrst_pre_csb: got %b want 0", bus_a.o_spi_csb); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus_a.o_spi_csb !== 1'b1) begin n_bad++; $display("FAIL midrst_csb: got %b want 1", bus_a.o_spi_csb); end
    n_cmp++; if (bus_a.o_spi_sclk !== 1'b0) begin n_bad++; $display("FAIL midrst_sclk: got %b want 0", bus_a.o_spi_sclk); end
    n_cmp++; if (bus_a.o_spi_mosi !== 1'b0) begin n_bad++; $display("FAIL midrst_mosi: got %b want 0", bus_a.o_spi_mosi); end
    n_cmp++; if (bus_a.o_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", bus_a.o_ready); end
    @(negedge clk);
    rst = 1'b0;
    capture(1'b0, 150, -1);
    analyze(150, 16, 4, 16'h0000);
    n_cmp++; if (n_vld !== 0) begin n_bad++; $display("FAIL midrst_no_vld: got %0d pulses want 0", n_vld); end
    n_cmp++; if (rx_last !== 16'h0) begin n_bad++; $display("FAIL midrst_rxdata: got %h want 0000", rx_last); end
  endtask

  task automatic test_loopback;
    logic [15:0] tx;
    loop_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx = (i == 0) ? 16'hA55A : 16'($urandom);
      launch(1'b0, tx, 1'b0);
      capture(1'b0, 140, -1);
      analyze(140, 16, 4, tx);
      n_cmp++; if (n_rise !== 16) begin n_bad++; $display("FAIL lb_rises[%0d]: got %0d want 16", i, n_rise); end
      n_cmp++; if (j_vld !== 132) begin n_bad++; $display("FAIL lb_vld_time[%0d]: got %0d want 132", i, j_vld); end
      n_cmp++; if (n_vld !== 1) begin n_bad++; $display("FAIL lb_vld_pulses[%0d]: got %0d want 1", i, n_vld); end
      n_cmp++; if (n_csblow !== 132) begin n_bad++; $display("FAIL lb_csb_low[%0d]: got %0d want 132", i, n_csblow); end
      n_cmp++; if (j_rdy !== 135) begin n_bad++; $display("FAIL lb_ready_time[%0d]: got %0d want 135", i, j_rdy); end
      n_cmp++; if (rx_last !== tx) begin n_bad++; $display("FAIL lb_rxdata[%0d]: got %h want %h", i, rx_last, tx); end
      n_cmp++; if (sclk_err !== 0) begin n_bad++; $display("FAIL lb_sclk_wave[%0d]: got %0d bad cycles want 0", i, sclk_err); end
      n_cmp++; if (mosi_err !== 0) begin n_bad++; $display("FAIL lb_mosi_wave[%0d]: got %0d bad cycles want 0", i, mosi_err); end
    end
  endtask

  task automatic test_slave;
    logic [15:0] tx;
    loop_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx       = (i == 0) ? 16'h8012 : 16'($urandom);
      slave_tx = (i == 0) ? 16'h3C81 : 16'($urandom);
      launch(1'b0, tx, 1'b0);
      capture(1'b0, 140, -1);
      analyze(140, 16, 4, tx);
      n_cmp++; if (slave_rx !== tx) begin n_bad++; $display("FAIL sl_slave_rx[%0d]: got %h want %h", i, slave_rx, tx); end
      n_cmp++; if (rx_last !== slave_tx) begin n_bad++; $display("FAIL sl_rxdata[%0d]: got %h want %h", i, rx_last, slave_tx); end
      n_cmp++; if (c_mosi[131] !== 1'b0) begin n_bad++; $display("FAIL sl_mosi_after_last[%0d]: got %b want 0", i, c_mosi[131]); end
      n_cmp++; if (mosi_err !== 0) begin n_bad++; $display("FAIL sl_mosi_wave[%0d]: got %0d bad cycles want 0", i, mosi_err); end
    end
    loop_a = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [15:0] tx1, tx2, rx1, rx2;
    int e0, e1, hi, w;
    bit got1, got2;
    loop_a = 1'b1;
    tx1 = 16'($urandom); tx2 = 16'($urandom);
    hi = 0; e0 = 0; e1 = -1; got1 = 0; got2 = 0; rx1 = '0; rx2 = '0;
    @(negedge clk);
    bus_a.i_tx_data = tx1;
    bus_a.i_start   = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    bus_a.i_tx_data = tx2;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      if (bus_a.o_rx_vld === 1'b1) begin rx1 = bus_a.o_rx_data; got1 = 1; end
      if (bus_a.o_spi_csb === 1'b1) hi++;
      else if (hi > 0) begin e1 = cyc; break; end
    end
    bus_a.i_start = 1'b0;
    w = 0;
    while (!got2 && w < 300) begin
      @(negedge clk);
      if (bus_a.o_rx_vld === 1'b1) begin rx2 = bus_a.o_rx_data; got2 = 1; end
      w++;
    end
    n_cmp++; if (e1 - e0 !== 136) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 136", e1 - e0); end
    n_cmp++; if (hi !== 4) begin n_bad++; $display("FAIL b2b_csb_high: got %0d want 4", hi); end
    n_cmp++; if (!got1 || rx1 !== tx1) begin n_bad++; $display("FAIL b2b_rx1: got %h want %h", rx1, tx1); end
    n_cmp++; if (!got2 || rx2 !== tx2) begin n_bad++; $display("FAIL b2b_rx2: got %h want %h", rx2, tx2); end
  endtask

  task automatic test_abort;
    logic [15:0] p, q;
    loop_a = 1'b1;
    p = 16'($urandom); q = ~p;
    launch(1'b0, p, 1'b0);
    capture(1'b0, 140, -1);
    launch(1'b0, q, 1'b0);
    capture(1'b0, 60, 44);
    analyze(60, 16, 4, q);
    n_cmp++; if (c_csb[43] !== 1'b0 || c_sclk[43] !== 1'b0) begin n_bad++; $display("FAIL ab_pre: got csb=%b sclk=%b want 0 0", c_csb[43], c_sclk[43]); end
    n_cmp++; if (c_csb[44] !== 1'b1) begin n_bad++; $display("FAIL ab_csb: got %b want 1", c_csb[44]); end
    n_cmp++; if (c_sclk[44] !== 1'b0) begin n_bad++; $display("FAIL ab_sclk: got %b want 0", c_sclk[44]); end
    n_cmp++; if (c_mosi[44] !== 1'b0) begin n_bad++; $display("FAIL ab_mosi: got %b want 0", c_mosi[44]); end
    n_cmp++; if (n_vld !== 0) begin n_bad++; $display("FAIL ab_no_vld: got %0d want 0", n_vld); end
    n_cmp++; if (rx_last !== p) begin n_bad++; $display("FAIL ab_rx_kept: got %h want %h", rx_last, p); end
    n_cmp++; if (j_rdy !== 47) begin n_bad++; $display("FAIL ab_ready_time: got %0d want 47", j_rdy); end
    // Abort together with start in IDLE: start wins and the frame runs normally.
    q = 16'($urandom);
    launch(1'b0, q, 1'b1);
    capture(1'b0, 140, -1);
    analyze(140, 16, 4, q);
    n_cmp++; if (j_vld !== 132) begin n_bad++; $display("FAIL abst_vld_time: got %0d want 132", j_vld); end
    n_cmp++; if (rx_last !== q) begin n_bad++; $display("FAIL abst_rxdata: got %h want %h", rx_last, q); end
  endtask

  task automatic test_small_fast;
    logic [15:0] tx;
    for (int i = 0; i < 3; i++) begin
      tx = (i == 0) ? 16'h00C3 : {8'h00, 8'($urandom)};
      launch(1'b1, tx, 1'b0);
      capture(1'b1, 40, -1);
      analyze(40, 8, 1, tx);
      n_cmp++; if (n_rise !== 8) begin n_bad++; $display("FAIL sf_rises[%0d]: got %0d want 8", i, n_rise); end
      n_cmp++; if (sclk_err !== 0) begin n_bad++; $display("FAIL sf_sclk_wave[%0d]: got %0d bad cycles want 0", i, sclk_err); end
      n_cmp++; if (n_csblow !== 17) begin n_bad++; $display("FAIL sf_csb_low[%0d]: got %0d want 17", i, n_csblow); end
      n_cmp++; if (j_vld !== 17) begin n_bad++; $display("FAIL sf_vld_time[%0d]: got %0d want 17", i, j_vld); end
      n_cmp++; if (j_rdy !== 20) begin n_bad++; $display("FAIL sf_ready_time[%0d]: got %0d want 20", i, j_rdy); end
      n_cmp++; if (rx_last !== tx) begin n_bad++; $display("FAIL sf_rxdata[%0d]: got %h want %h", i, rx_last, tx); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    loop_a = 1'b1;
    bus_a.i_start = 1'b0; bus_a.i_abort = 1'b0; bus_a.i_tx_data = '0;
    bus_b.i_start = 1'b0; bus_b.i_abort = 1'b0; bus_b.i_tx_data = '0;
    repeat (3) @(negedge clk);
    test_reset;
    test_loopback;
    test_slave;
    test_back_to_back;
    test_abort;
    test_small_fast;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
